// File: rtl/rocketcpu_wb_interconnect_if.sv
// Wishbone bus bundle between the master port and the N-slave fabric.
// Signal names are from the interconnect's point of view (i_ = into the interconnect).
interface rocketcpu_wb_interconnect_if #(
    parameter int unsigned NUM_SLAVES = 8
);
    logic [31:0]              i_wb_adr;
    logic [31:0]              i_wb_dat;
    logic [3:0]               i_wb_sel;
    logic                     i_wb_we;
    logic                     i_wb_cyc;
    logic [31:0]              o_wb_rdt;
    logic                     o_wb_ack;
    logic                     o_wb_err;
    logic [NUM_SLAVES-1:0]    o_s_cyc;
    logic [31:0]              o_s_adr;
    logic [31:0]              o_s_dat;
    logic [3:0]               o_s_sel;
    logic                     o_s_we;
    logic [NUM_SLAVES*32-1:0] i_s_rdt;
    logic [NUM_SLAVES-1:0]    i_s_ack;

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack, o_wb_err,
        output o_s_cyc, o_s_adr, o_s_dat, o_s_sel, o_s_we,
        input  i_s_rdt, i_s_ack
    );

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack, o_wb_err,
        input  o_s_cyc, o_s_adr, o_s_dat, o_s_sel, o_s_we,
        output i_s_rdt, i_s_ack
    );
endinterface

// File: rtl/rocketcpu_wb_interconnect.sv
// Wishbone 1-to-N interconnect: table decode, registered response, bus error and timeout.
// Optional error interrupt enabled by defining WB_INTERCONNECT_ERR_IRQ_EN.
module rocketcpu_wb_interconnect #(
    parameter int unsigned              NUM_SLAVES = 8,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
    parameter logic [NUM_SLAVES-1:0]    AUTO_ACK   = '0,
    parameter int unsigned              TIMEOUT    = 255
) (
    input  logic                              i_wb_clk,
    input  logic                              reset_n,
    rocketcpu_wb_interconnect_if.slave        bus,
`ifdef WB_INTERCONNECT_ERR_IRQ_EN
    output logic                              o_err_irq,
    input  logic                              i_err_clr,
`endif
    output logic [31:0]                       o_err_adr,
    output logic [15:0]                       o_err_count
);

    typedef enum logic [1:0] {StIdle, StBusy, StErr, StDone} state_e;

    state_e                r_state, w_state_d;
    logic [NUM_SLAVES-1:0] r_sel, w_sel_d;
    logic [15:0]           r_cnt, w_cnt_d;
    logic [31:0]           r_rdt, w_rdt_d;
    logic                  r_ack, w_ack_d;
    logic                  r_err, w_err_d;
    logic [31:0]           r_err_adr, w_err_adr_d;
    logic [15:0]           r_err_count, w_err_count_d;

    logic [NUM_SLAVES-1:0] w_hit, w_dec, w_s_cyc;
    logic [31:0]           w_sel_rdt;
    logic                  w_resp;

    // Lowest-index hit wins: isolate the least significant set bit.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            w_hit[i] = (bus.i_wb_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32];
        end
        w_dec = w_hit & (~w_hit + NUM_SLAVES'(1));
    end

    always_comb begin
        w_sel_rdt = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (r_sel[i]) w_sel_rdt = bus.i_s_rdt[32*i +: 32];
        end
    end

    assign w_resp = |(r_sel & (bus.i_s_ack | AUTO_ACK));

    always_comb begin
        w_state_d     = r_state;
        w_sel_d       = r_sel;
        w_cnt_d       = r_cnt;
        w_rdt_d       = r_rdt;
        w_ack_d       = 1'b0;
        w_err_d       = 1'b0;
        w_err_adr_d   = r_err_adr;
        w_err_count_d = r_err_count;
        w_s_cyc       = '0;
        case (r_state)
            StIdle: begin
                if (bus.i_wb_cyc) begin
                    if (|w_dec) begin
                        w_sel_d   = w_dec;
                        w_cnt_d   = '0;
                        w_state_d = StBusy;
                    end else begin
                        w_state_d = StErr;
                    end
                end
            end
            StBusy: begin
                if (!bus.i_wb_cyc) begin
                    w_state_d = StIdle;
                end else begin
                    w_s_cyc = r_sel;
                    w_cnt_d = r_cnt + 16'd1;
                    if (w_resp) begin
                        w_rdt_d   = w_sel_rdt;
                        w_ack_d   = 1'b1;
                        w_state_d = StDone;
                    end else if (r_cnt == 16'(TIMEOUT - 1)) begin
                        w_state_d = StErr;
                    end
                end
            end
            StErr: begin
                w_ack_d       = 1'b1;
                w_err_d       = 1'b1;
                w_rdt_d       = '0;
                w_err_adr_d   = bus.i_wb_adr;
                w_err_count_d = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;
                w_state_d     = StDone;
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_rdt       <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_err_adr   <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_d;
            r_sel       <= w_sel_d;
            r_cnt       <= w_cnt_d;
            r_rdt       <= w_rdt_d;
            r_ack       <= w_ack_d;
            r_err       <= w_err_d;
            r_err_adr   <= w_err_adr_d;
            r_err_count <= w_err_count_d;
        end
    end

`ifdef WB_INTERCONNECT_ERR_IRQ_EN
    logic r_irq;

    // Error set has priority over a clear in the same cycle.
    always_ff @(posedge i_wb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (r_err) begin
            r_irq <= 1'b1;
        end else if (i_err_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign o_err_irq = r_irq | r_err;
`endif

    assign bus.o_s_adr  = bus.i_wb_adr;
    assign bus.o_s_dat  = bus.i_wb_dat;
    assign bus.o_s_sel  = bus.i_wb_sel;
    assign bus.o_s_we   = bus.i_wb_we;
    assign bus.o_s_cyc  = w_s_cyc;
    assign bus.o_wb_rdt = r_rdt;
    assign bus.o_wb_ack = r_ack;
    assign bus.o_wb_err = r_err;
    assign o_err_adr    = r_err_adr;
    assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_rocketcpu_wb_interconnect.sv
// Directed bench for rocketcpu_wb_interconnect with a response scoreboard.
module tb_rocketcpu_wb_interconnect;

    localparam int unsigned NS   = 2;
    localparam logic [63:0] BASE = {32'h0400_0000, 32'h0000_0000};
    localparam logic [63:0] MASK = {32'hFFFF_FFFF, 32'hFFFF_8000};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] err_adr;
    logic [15:0] err_count;
`ifdef WB_INTERCONNECT_ERR_IRQ_EN
    logic        err_irq;
    logic        err_clr = 1'b0;
`endif

    rocketcpu_wb_interconnect_if #(.NUM_SLAVES(NS)) bus ();

    rocketcpu_wb_interconnect #(
        .NUM_SLAVES (NS),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .AUTO_ACK   (2'b10),
        .TIMEOUT    (16)
    ) dut (
        .i_wb_clk    (clk),
        .reset_n     (rst_n),
        .bus         (bus.slave),
`ifdef WB_INTERCONNECT_ERR_IRQ_EN
        .o_err_irq   (err_irq),
        .i_err_clr   (err_clr),
`endif
        .o_err_adr   (err_adr),
        .o_err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rdt;
        logic        err;
    } resp_t;
    resp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input int budget, output int cycles);
        resp_t r;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.o_wb_ack && cycles < budget);
        check({tag, "_ack_seen"}, 32'(bus.o_wb_ack), 32'd1);
        if (bus.o_wb_ack) begin
            check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                r = sb_q.pop_front();
                check({tag, "_rdt"}, bus.o_wb_rdt, r.rdt);
                check({tag, "_err"}, 32'(bus.o_wb_err), 32'(r.err));
            end
        end
    endtask

    task automatic drive(input logic [31:0] adr, input logic we, input logic cyc);
        bus.i_wb_adr = adr;
        bus.i_wb_dat = adr ^ 32'h5A5A_A5A5;
        bus.i_wb_sel = 4'hF;
        bus.i_wb_we  = we;
        bus.i_wb_cyc = cyc;
    endtask

    // Starts and ends at a negedge with the interconnect idle.
    task automatic do_unmapped(input string tag, input logic [31:0] adr, input logic [15:0] cnt);
        int n;
        drive(adr, 1'b0, 1'b1);
        sb_q.push_back('{rdt: 32'h0, err: 1'b1});
        wait_ack(tag, 2, n);
        check({tag, "_latency"}, 32'(n), 32'd2);
        bus.i_wb_cyc = 1'b0;
        check({tag, "_err_adr"}, err_adr, adr);
        check({tag, "_err_count"}, 32'(err_count), 32'(cnt));
        @(negedge clk);
    endtask

    task automatic count_acks(input int ncyc, output int acks);
        acks = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.o_wb_ack) acks++;
        end
    endtask

    initial begin
        int n;
        drive(32'h0, 1'b0, 1'b0);
        bus.i_s_rdt = {32'hCAFE_F00D, 32'h0};
        bus.i_s_ack = '0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.o_wb_ack), 32'd0);
        check("rst_err", 32'(bus.o_wb_err), 32'd0);
        check("rst_rdt", bus.o_wb_rdt, 32'd0);
        check("rst_s_cyc", 32'(bus.o_s_cyc), 32'd0);
        check("rst_err_adr", err_adr, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        drive(32'hDEAD_BEE0, 1'b1, 1'b0);
        #1;
        check("bc_adr", bus.o_s_adr, 32'hDEAD_BEE0);
        check("bc_dat", bus.o_s_dat, 32'hDEAD_BEE0 ^ 32'h5A5A_A5A5);
        check("bc_sel", 32'(bus.o_s_sel), 32'hF);
        check("bc_we", 32'(bus.o_s_we), 32'd1);
        @(negedge clk);

        // slave0 read, slave acks three cycles after it first sees cyc
        drive(32'h0000_0010, 1'b0, 1'b1);
        sb_q.push_back('{rdt: 32'h1234_5678, err: 1'b0});
        @(negedge clk);
        check("rd0_s_cyc", 32'(bus.o_s_cyc), 32'b01);
        repeat (3) @(negedge clk);
        check("rd0_no_early_ack", 32'(bus.o_wb_ack), 32'd0);
        bus.i_s_ack = 2'b01;
        bus.i_s_rdt = {32'hCAFE_F00D, 32'h1234_5678};
        wait_ack("rd0", 1, n);
        bus.i_wb_cyc = 1'b0;
        bus.i_s_ack  = '0;
        @(negedge clk);
        check("rd0_ack_pulse", 32'(bus.o_wb_ack), 32'd0);
        check("rd0_rdt_hold", bus.o_wb_rdt, 32'h1234_5678);

        // AUTO_ACK write to slave1
        drive(32'h0400_0000, 1'b1, 1'b1);
        sb_q.push_back('{rdt: 32'hCAFE_F00D, err: 1'b0});
        @(negedge clk);
        check("aa_s_cyc", 32'(bus.o_s_cyc), 32'b10);
        wait_ack("aa", 1, n);
        check("aa_s_cyc_single", 32'(bus.o_s_cyc), 32'd0);
        bus.i_wb_cyc = 1'b0;
        @(negedge clk);

        do_unmapped("unmap", 32'h0700_0000, 16'd1);
`ifdef WB_INTERCONNECT_ERR_IRQ_EN
        check("irq_set_unmap", 32'(err_irq), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("irq_clr_unmap", 32'(err_irq), 32'd0);
`endif

        // slave0 never acks: 16 BUSY cycles, ERR, then ack
        drive(32'h0000_0020, 1'b0, 1'b1);
        sb_q.push_back('{rdt: 32'h0, err: 1'b1});
        wait_ack("tmo", 40, n);
        check("tmo_latency", 32'(n), 32'd18);
        bus.i_wb_cyc = 1'b0;
        check("tmo_err_adr", err_adr, 32'h0000_0020);
        check("tmo_err_count", 32'(err_count), 32'd2);
`ifdef WB_INTERCONNECT_ERR_IRQ_EN
        check("irq_set_tmo", 32'(err_irq), 32'd1);
        repeat (3) @(negedge clk);
        check("irq_hold_tmo", 32'(err_irq), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("irq_clr_tmo", 32'(err_irq), 32'd0);
`endif
        @(negedge clk);

        // slave ack already high when cyc arrives
        bus.i_s_ack = 2'b01;
        bus.i_s_rdt = {32'hCAFE_F00D, 32'hA5A5_5A5A};
        drive(32'h0000_0100, 1'b0, 1'b1);
        sb_q.push_back('{rdt: 32'hA5A5_5A5A, err: 1'b0});
        wait_ack("fast", 2, n);
        check("fast_latency", 32'(n), 32'd2);
        bus.i_wb_cyc = 1'b0;
        bus.i_s_ack  = '0;
        @(negedge clk);

        // master drops cyc in BUSY
        drive(32'h0000_0030, 1'b0, 1'b1);
        @(negedge clk);
        check("abort_s_cyc", 32'(bus.o_s_cyc), 32'b01);
        bus.i_wb_cyc = 1'b0;
        #1;
        check("abort_s_cyc_drop", 32'(bus.o_s_cyc), 32'd0);
        count_acks(6, n);
        check("abort_no_ack", 32'(n), 32'd0);
        check("abort_err_count", 32'(err_count), 32'd2);

        // reset during a fresh BUSY
        drive(32'h0000_0040, 1'b0, 1'b1);
        @(negedge clk);
        check("rstmid_s_cyc", 32'(bus.o_s_cyc), 32'b01);
        rst_n = 1'b0;
        #1;
        check("rstmid_s_cyc0", 32'(bus.o_s_cyc), 32'd0);
        check("rstmid_ack", 32'(bus.o_wb_ack), 32'd0);
        check("rstmid_rdt", bus.o_wb_rdt, 32'd0);
        check("rstmid_err_adr", err_adr, 32'd0);
        check("rstmid_err_count", 32'(err_count), 32'd0);
        bus.i_wb_cyc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_acks(5, n);
        check("rstmid_no_ack", 32'(n), 32'd0);

        // saturation: one normal increment, then preload near the top
        do_unmapped("sat0", 32'h0800_0000, 16'd1);
        force dut.r_err_count = 16'hFFFC;
        @(negedge clk);
        release dut.r_err_count;
        @(negedge clk);
        check("sat_preload", 32'(err_count), 32'hFFFC);
        do_unmapped("sat1", 32'h0800_0004, 16'hFFFD);
        do_unmapped("sat2", 32'h0800_0008, 16'hFFFE);
        do_unmapped("sat3", 32'h0800_000C, 16'hFFFF);
        do_unmapped("sat4", 32'h0800_0010, 16'hFFFF);
        do_unmapped("sat5", 32'h0800_0014, 16'hFFFF);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/rocketcpu_wb_interconnect.md
Name: rocketcpu_wb_interconnect

Overview:
- Parametrised Wishbone single-master to N-slave interconnect.
- Replaces the hand-written address-decode, read-data mux and ack mux in the CPU top with one block: table-driven decode, registered response path, bus-error and timeout handling.
- Sits between the ibus/dbus arbiter output and all memory-mapped peripherals (RAM, flash, UART, timers, IRQ, audio registers, ...).
- Ackless peripherals (GPIO, timers, LEDs) are acked automatically.

Parameters:
NUM_SLAVES, 8, number of slave ports (1..16)
SLAVE_BASE, all zeros, NUM_SLAVES*32-bit flattened vector; slave i base in bits [32*i+31:32*i]
SLAVE_MASK, all zeros, NUM_SLAVES*32-bit flattened vector; slave i hits when (adr & MASK_i) == BASE_i
AUTO_ACK, 0, NUM_SLAVES-bit mask; bit i set means slave i has no ack output and the interconnect generates it
TIMEOUT, 255, cycles in BUSY before a forced error response (1..65535)

Ports:
i_wb_clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_wb_adr  in  32  master address
i_wb_dat  in  32  master write data
i_wb_sel  in  4  byte selects
i_wb_we  in  1  write enable
i_wb_cyc  in  1  master cycle request
o_wb_rdt  out  32  read data, registered
o_wb_ack  out  1  one-cycle transfer acknowledge
o_wb_err  out  1  error qualifier, valid only with o_wb_ack
o_s_cyc  out  NUM_SLAVES  one-hot per-slave cycle
o_s_adr  out  32  address broadcast
o_s_dat  out  32  write data broadcast
o_s_sel  out  4  byte select broadcast
o_s_we  out  1  write enable broadcast
i_s_rdt  in  NUM_SLAVES*32  flattened slave read data
i_s_ack  in  NUM_SLAVES  slave acks; ignored for AUTO_ACK slaves
o_err_adr  out  32  address of the last errored transfer
o_err_count  out  16  saturating count of errored transfers

Behaviour:
- Reset (async assert, sync deassert by user): state=IDLE; o_wb_ack=0, o_wb_err=0, o_wb_rdt=0, o_s_cyc=0, o_err_adr=0, o_err_count=0, timeout counter=0.
- Broadcasts o_s_adr/dat/sel/we are combinational pass-throughs of the master inputs.
- Decode is combinational. The lowest-index hit wins on overlap.
- FSM IDLE:
  - i_wb_cyc=1 and a hit: latch the one-hot select into sel_q, clear the counter, go to BUSY.
  - i_wb_cyc=1 and no hit: go to ERR.
- FSM BUSY:
  - o_s_cyc = sel_q when i_wb_cyc=1, else 0.
  - Counter increments every cycle.
  - Response condition: i_s_ack of the selected slave, or the selected slave is AUTO_ACK. An AUTO_ACK slave therefore sees exactly one cycle of cyc.
  - On the response condition: register o_wb_rdt = i_s_rdt[selected], pulse o_wb_ack=1, o_wb_err=0 next cycle, go to DONE.
  - Counter == TIMEOUT-1 without a response: go to ERR.
  - i_wb_cyc drops in BUSY: abort to IDLE with no ack and no error count.
- FSM ERR (one cycle):
  - o_s_cyc=0.
  - Next cycle o_wb_ack=1, o_wb_err=1, o_wb_rdt=0.
  - o_err_adr = i_wb_adr; o_err_count += 1, saturating at 0xFFFF.
  - Go to DONE.
- FSM DONE (one cycle): o_s_cyc=0; ack is asserted this cycle; go to IDLE. This enforces one idle cycle between transfers, so back-to-back cyc from the arbiter is never acked twice.
- Latency:
  - Slave ack in cycle N gives o_wb_ack in N+1.
  - AUTO_ACK: cyc accepted in cycle 0 gives o_wb_ack in cycle 2.
  - Unmapped address: o_wb_ack in cycle 2.
- o_wb_rdt holds its value until the next ack; it is 0 after an error ack.
- Reset asserted mid-transfer: immediate return to IDLE; no ack is ever emitted for the aborted transfer.

Optional Feature:
- Macro: WB_INTERCONNECT_ERR_IRQ_EN.
- Defined:
  - Adds output o_err_irq (1) and input i_err_clr (1).
  - o_err_irq is set the cycle o_wb_err is asserted and stays high until i_err_clr=1.
  - Set wins over simultaneous clear.
  - Reset value 0.
- Not defined: both ports are absent and no IRQ logic is built.

Test Plan:
- NUM_SLAVES=2; slave0 base 0x0000_0000 mask 0xFFFF_8000, slave1 0x0400_0000 mask 0xFFFF_FFFF. Read 0x0000_0010; slave0 acks 3 cycles after cyc with 0x12345678 -> o_s_cyc=2'b01, o_wb_ack one cycle after slave ack, o_wb_rdt=0x12345678, o_wb_err=0.
- Slave1 AUTO_ACK; write 0x0400_0000 -> o_s_cyc[1] high exactly one cycle, o_wb_ack in cycle 2, no error.
- Read 0x0700_0000 (unmapped) -> o_wb_ack=1, o_wb_err=1, o_wb_rdt=0, o_err_adr=0x0700_0000, o_err_count=1.
- TIMEOUT=16; slave0 never acks -> error ack after 16 BUSY cycles, o_err_count increments; with WB_INTERCONNECT_ERR_IRQ_EN defined, o_err_irq=1 until i_err_clr pulse.
- Drop i_wb_cyc in BUSY, then assert reset_n=0 during a fresh BUSY -> no ack either time, o_err_count unchanged, all outputs at reset values.
- 70000 unmapped accesses -> o_err_count saturates at 0xFFFF.
